// File: rtl/fpu_ctrl.sv
// Multi-cycle FP instruction sequencer: decodes COP1 add/sub/mul, lwc1 and swc1,
// stalls the core while an op is in flight and drives the FPU write controls.
module fpu_ctrl #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] fpu_instruction,
  output logic        regdst,
  output logic        fpuregwritemux,
  output logic        fpu_regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned CNT_W = 4;
  localparam logic [5:0] OP_COP1 = 6'b010001;
  localparam logic [5:0] OP_LWC1 = 6'b110001;
  localparam logic [5:0] OP_SWC1 = 6'b111001;
  localparam logic [5:0] FN_MUL  = 6'd2;

  typedef enum logic [2:0] {IDLE, EXEC, WB, MEM, LDWB} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [31:0]        instr_next;
  logic               done_next, illegal_next;
  logic [5:0]         opcode, funct;
  logic               is_load;

  assign opcode  = instruction[31:26];
  assign funct   = instruction[5:0];
  // The latched opcode tells MEM whether this access is a load or a store.
  assign is_load = (fpu_instruction[31:26] == OP_LWC1);

  // State, counter, latched instruction and the registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      count           <= '0;
      fpu_instruction <= '0;
      done            <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      state           <= state_next;
      count           <= count_next;
      fpu_instruction <= instr_next;
      done            <= done_next;
      illegal         <= illegal_next;
    end
  end

  // Next-state, acceptance and pulse generation.
  always_comb begin
    state_next   = state;
    count_next   = count;
    instr_next   = fpu_instruction;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (opcode == OP_COP1) begin
            if (funct <= FN_MUL) begin
              state_next = EXEC;
              instr_next = instruction;
              count_next = (funct == FN_MUL) ? CNT_W'(MUL_LAT - 1)
                                             : CNT_W'(ADD_LAT - 1);
            end else begin
              illegal_next = 1'b1;
            end
          end else if (opcode == OP_LWC1 || opcode == OP_SWC1) begin
            state_next = MEM;
            instr_next = instruction;
          end
        end
      end
      EXEC: begin
        if (count == '0) state_next = WB;
        else             count_next = count - CNT_W'(1);
      end
      WB: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            state_next = LDWB;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      LDWB: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // FPU and memory controls decoded from the registered state only.
  always_comb begin
    regdst         = 1'b0;
    fpuregwritemux = 1'b0;
    fpu_regwrite   = 1'b0;
    memread        = 1'b0;
    memwrite       = 1'b0;
    case (state)
      WB:   fpu_regwrite = 1'b1;
      MEM: begin
        regdst   = 1'b1;
        memread  = is_load;
        memwrite = !is_load;
      end
      LDWB: begin
        regdst         = 1'b1;
        fpuregwritemux = 1'b1;
        fpu_regwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall = (state != IDLE);

endmodule

// File: tb/tb_fpu_ctrl.sv
// Self-checking bench for fpu_ctrl: directed scenarios then random instruction
// streams, each checked against a per-cycle expected-output timeline.
module tb_fpu_ctrl;

  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned MUL_LAT = 3;
  localparam logic [5:0] OP_COP1 = 6'b010001;
  localparam logic [5:0] OP_LWC1 = 6'b110001;
  localparam logic [5:0] OP_SWC1 = 6'b111001;

  // Control vector order: stall, regdst, mux, regwrite, memread, memwrite, done, illegal
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_EXEC = 8'b1000_0000;
  localparam logic [7:0] V_WB   = 8'b1001_0000;
  localparam logic [7:0] V_LDM  = 8'b1100_1000;
  localparam logic [7:0] V_LDWB = 8'b1111_0000;
  localparam logic [7:0] V_STM  = 8'b1100_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        stall, regdst, fpuregwritemux, fpu_regwrite, memread, memwrite, done, illegal;
  logic [31:0] fpu_instruction;
  logic [7:0]  ctrl;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_fi = '0;
  logic        pend_done = 1'b0;
  logic        pend_ill = 1'b0;

  fpu_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .mem_ready(mem_ready), .stall(stall), .fpu_instruction(fpu_instruction),
    .regdst(regdst), .fpuregwritemux(fpuregwritemux), .fpu_regwrite(fpu_regwrite),
    .memread(memread), .memwrite(memwrite), .done(done), .illegal(illegal)
  );

  assign ctrl = {stall, regdst, fpuregwritemux, fpu_regwrite, memread, memwrite, done, illegal};

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Any recognised FP instruction; used as noise while the sequencer is busy.
  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return {OP_COP1, r[25:6], 6'($urandom_range(0, 2))};
      1:       return {OP_LWC1, r[25:0]};
      default: return {OP_SWC1, r[25:0]};
    endcase
  endfunction

  // One clock: drive inputs, sample at negedge, return just after the next rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic mr,
                      input logic [7:0] ev, input string tag);
    logic [7:0] evf;
    instr_valid = v;
    instruction = ins;
    mem_ready   = mr;
    evf = ev | {6'b0, pend_done, pend_ill};
    pend_done = 1'b0;
    pend_ill  = 1'b0;
    @(negedge clk);
    tests++;
    assert (ctrl === evf) else begin
      fails++;
      $error("FAIL %s ctrl: got %b exp %b", tag, ctrl, evf);
    end
    tests++;
    assert (fpu_instruction === exp_fi) else begin
      fails++;
      $error("FAIL %s fpu_instruction: got %h exp %h", tag, fpu_instruction, exp_fi);
    end
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IDLE and walk its full expected timeline.
  task automatic issue(input logic [31:0] ins, input int k);
    logic [5:0] op;
    logic [5:0] fn;
    int lat;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == OP_COP1 && fn <= 6'd2) begin
      lat = (fn == 6'd2) ? int'(MUL_LAT) : int'(ADD_LAT);
      step(1'b1, ins, rbit(), V_IDLE, "accept_cop1");
      exp_fi = ins;
      for (int i = 0; i < lat; i++) step(rbit(), rand_fp(), rbit(), V_EXEC, "exec");
      step(rbit(), rand_fp(), rbit(), V_WB, "wb");
      pend_done = 1'b1;
    end else if (op == OP_LWC1) begin
      step(1'b1, ins, rbit(), V_IDLE, "accept_lw");
      exp_fi = ins;
      for (int i = 0; i < k; i++) step(rbit(), rand_fp(), 1'b0, V_LDM, "lw_wait");
      step(rbit(), rand_fp(), 1'b1, V_LDM, "lw_ready");
      step(rbit(), rand_fp(), rbit(), V_LDWB, "ldwb");
      pend_done = 1'b1;
    end else if (op == OP_SWC1) begin
      step(1'b1, ins, rbit(), V_IDLE, "accept_sw");
      exp_fi = ins;
      for (int i = 0; i < k; i++) step(rbit(), rand_fp(), 1'b0, V_STM, "sw_wait");
      step(rbit(), rand_fp(), 1'b1, V_STM, "sw_ready");
      pend_done = 1'b1;
    end else if (op == OP_COP1) begin
      step(1'b1, ins, rbit(), V_IDLE, "illegal_funct");
      pend_ill = 1'b1;
    end else begin
      step(1'b1, ins, rbit(), V_IDLE, "non_fp");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, rbit(), V_IDLE, "idle");
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    reset = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    mem_ready = 1'b0;

    step(1'b1, 32'h4402_0840, 1'b1, V_IDLE, "reset_state");
    step(1'b1, 32'hC400_0000, 1'b1, V_IDLE, "reset_state2");
    reset = 1'b1;
    idle(1);

    issue(32'h4402_0840, 0);       // add
    idle(1);
    issue(32'h4402_0842, 0);       // mul
    issue(32'hC443_0010, 4);       // lwc1, mem_ready low for 4 cycles (back-to-back)
    idle(1);
    issue(32'hE443_0020, 0);       // swc1 immediate
    idle(1);
    issue(32'h4402_0847, 0);       // funct 7
    idle(1);
    issue(32'h0000_0000, 0);       // non-FP opcode
    idle(1);

    // Reset during the second EXEC cycle of a mul.
    step(1'b1, 32'h4402_0842, 1'b0, V_IDLE, "rst_accept");
    exp_fi = 32'h4402_0842;
    step(1'b1, 32'h4402_0842, 1'b0, V_EXEC, "rst_exec1");
    reset = 1'b0;
    #1;
    tests++;
    assert (ctrl === V_IDLE && fpu_instruction === 32'h0) else begin
      fails++;
      $error("FAIL async_reset: got ctrl %b fi %h exp ctrl 00000000 fi 0", ctrl, fpu_instruction);
    end
    exp_fi = '0;
    step(1'b1, 32'h4402_0842, 1'b1, V_IDLE, "in_reset");
    step(1'b1, 32'hC400_0000, 1'b1, V_IDLE, "in_reset2");
    reset = 1'b1;
    idle(2);
    issue(32'h4402_0840, 0);
    idle(1);

    // Random instruction streams, including back-to-back issue.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 5))
        0, 1:    ins = {OP_COP1, 20'($urandom), 6'($urandom_range(0, 2))};
        2:       ins = {OP_LWC1, 26'($urandom)};
        3:       ins = {OP_SWC1, 26'($urandom)};
        4:       ins = {OP_COP1, 20'($urandom), 6'($urandom_range(3, 63))};
        default: begin
          do begin
            ins = $urandom;
            op  = ins[31:26];
          end while (op == OP_COP1 || op == OP_LWC1 || op == OP_SWC1);
        end
      endcase
      issue(ins, int'($urandom_range(0, 5)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_ctrl.md
# fpu_ctrl

Multi-cycle control sequencer that sits directly upstream of the FPU datapath. It decodes each FP instruction handed over by the integer core: COP1 add/sub/mul, lwc1 and swc1. It drives the FPU's `regdst`, `fpuregwritemux` and `fpu_regwrite` lines, and it stalls the core while an operation is in flight. It lets the datapath take a parameterised number of cycles per arithmetic op and wait on a memory handshake for loads and stores.

## Interface
Parameters:
- `ADD_LAT`, default 1: execute cycles for add/sub; legal range 1..15.
- `MUL_LAT`, default 3: execute cycles for mul; legal range 1..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `instr_valid`  in  1  core presents an instruction this cycle.
- `instruction`  in  32  instruction word from the core.
- `mem_ready`  in  1  data memory has completed the current lwc1/swc1 access.
- `stall`  out  1  core must hold its instruction; combinational, `state != IDLE`.
- `fpu_instruction`  out  32  latched instruction driven to the FPU.
- `regdst`  out  1  FPU write-address select (1 = instruction[20:16]).
- `fpuregwritemux`  out  1  FPU write-data select (1 = memory).
- `fpu_regwrite`  out  1  FPU register-file write enable.
- `memread`  out  1  data-memory read request (lwc1).
- `memwrite`  out  1  data-memory write request (swc1).
- `done`  out  1  one-cycle pulse when an accepted instruction completes.
- `illegal`  out  1  one-cycle pulse when a COP1 funct is unsupported.

## Operation
- Decode uses opcode `instruction[31:26]`:
  - COP1 = 6'b010001; the funct field `instruction[5:0]` must be 0 (add), 1 (sub) or 2 (mul).
  - lwc1 = 6'b110001.
  - swc1 = 6'b111001.
  - Any other opcode is ignored: not accepted, no stall, no pulse.
- States: IDLE, EXEC, WB, MEM, LDWB.
- IDLE:
  - An instruction is accepted when `instr_valid`=1 and the opcode is recognised.
  - On acceptance, `instruction` is latched into `fpu_instruction`. `fpu_instruction` holds its value until the next acceptance.
- Transitions out of IDLE:
  - COP1 with funct 0/1/2: go to EXEC. The 4-bit counter is loaded with LAT-1, where LAT = MUL_LAT for funct 2 and ADD_LAT otherwise.
  - COP1 with funct > 2: no acceptance. `illegal` pulses next cycle and the state stays IDLE.
  - lwc1 or swc1: go to MEM.
- EXEC: the counter decrements each cycle. When the counter is 0, go to WB.
- WB: `fpu_regwrite`=1, `regdst`=0, `fpuregwritemux`=0 for exactly one cycle, then go to IDLE.
- MEM, lwc1 case:
  - `memread`=1 and `regdst`=1.
  - Hold until `mem_ready`=1, then go to LDWB.
- LDWB: `fpu_regwrite`=1, `regdst`=1, `fpuregwritemux`=1 for one cycle, then go to IDLE.
- MEM, swc1 case:
  - `memwrite`=1 and `regdst`=1.
  - Hold until `mem_ready`=1, then go to IDLE. No register write occurs.
- `mem_ready` is ignored in every state other than MEM.
- `done` is registered. It is high in the first IDLE cycle after WB, after LDWB, or after MEM completes an swc1.
- Single issue, blocking: no new instruction is accepted outside IDLE. `instr_valid` is ignored while `stall`=1.
- Reset values: state=IDLE, counter=0, `fpu_instruction`=0, and all control outputs 0 (`stall`, `regdst`, `fpuregwritemux`, `fpu_regwrite`, `memread`, `memwrite`, `done`, `illegal`).
- Reset asserted mid-operation aborts immediately with no write and no `done` pulse.

## Timing
- Accept edge T: `stall` is 0 during cycle T and 1 from T+1.
- COP1 op:
  - EXEC occupies T+1..T+LAT.
  - WB occurs at T+LAT+1.
  - `done` and IDLE at T+LAT+2.
  - `stall` is high for LAT+1 cycles.
- lwc1 with `mem_ready` first sampled high in MEM cycle M: LDWB at M+1, `done` at M+2. The minimum MEM residence is 1 cycle.
- swc1 completing in cycle M: `done` at M+1.
- Back-to-back operation: a new instruction may be accepted in the same cycle `done` is high.
- All control outputs other than `stall` are decoded from the registered state. They are glitch-free relative to `clk`.

## Test plan
- Reset released, then COP1 add: `instruction`=32'h4402_0840 (fs=1, ft=2, fd=1, funct 0). Required: `stall` high for 2 cycles, `fpu_regwrite`=1 in the cycle after EXEC with `regdst`=0, `done` 1 cycle later.
- COP1 mul (funct 2) with MUL_LAT=3. Required: EXEC for 3 cycles, WB in cycle T+4, `done` at T+5. `instr_valid` held high throughout is not re-accepted until IDLE.
- lwc1 with `mem_ready` held low for 4 cycles, then high. Required: `memread`=1 and `regdst`=1 for 5 cycles, then one LDWB cycle with `fpu_regwrite`=1 and `fpuregwritemux`=1, then `done`.
- swc1 with `mem_ready`=1 immediately. Required: `memwrite`=1 for 1 cycle, `fpu_regwrite` never asserted, `done` next cycle.
- COP1 with funct 6'b000111. Required: `illegal` pulses once, `stall` stays 0, no write. A non-FP opcode (6'b000000) produces no response at all.
- Reset asserted (`reset`=0) during the second EXEC cycle of a mul. Required: all outputs 0 asynchronously, no WB, no `done`. After release, the next add completes normally.
